// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the irq_ctrl interrupt controller.
// Holds the FSM state encoding, the register offsets and the vector base.
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] REG_PENDING   = 2'd0;
    localparam logic [1:0] REG_MASK      = 2'd1;
    localparam logic [1:0] REG_INSERVICE = 2'd2;
    localparam logic [1:0] REG_EOI       = 2'd3;

    // The core adds this to the acknowledged ID to index its vector table.
    localparam logic [15:0] VECTOR_BASE = 16'h07F0;

endpackage

// File: rtl/irq_ctrl_if.sv
// Core-side bus of the interrupt controller: register access, acknowledge and INT.
// master = CPU core side, slave = irq_ctrl side.
interface irq_ctrl_if;
    logic [11:0] address;
    logic [15:0] wr_data;
    logic        memwt;
    logic        intack;
    logic        int_o;
    logic [15:0] rd_data;
    logic        rd_sel;

    modport master (
        output address, wr_data, memwt, intack,
        input  int_o, rd_data, rd_sel
    );

    modport slave (
        input  address, wr_data, memwt, intack,
        output int_o, rd_data, rd_sel
    );
endinterface

// File: rtl/irq_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder with valid flag and one-hot winner.
// WIDTH may be 1..16; idx is always 4 bits wide.
module irq_prio_enc #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] req,
    output logic             valid,
    output logic [3:0]       idx,
    output logic [WIDTH-1:0] onehot
);

    // Scan from the top so the lowest set index is the last assignment.
    always_comb begin
        valid = 1'b0;
        idx   = 4'd0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = 4'(i);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_onehot
            assign onehot[gi] = valid && (idx == 4'(gi));
        end
    endgenerate

endmodule

// File: rtl/irq_ctrl.sv
// Programmable interrupt controller: edge-triggered sources, mask, in-service tracking.
// Define IRQ_CTRL_NESTING_EN to let a higher-priority source preempt one in service.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int          NUM_IRQ   = 8,
    parameter logic [11:0] BASE_ADDR = 12'hFF0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq,
    irq_ctrl_if.slave          bus
);

    logic [NUM_IRQ-1:0] pending_reg, pending_next;
    logic [NUM_IRQ-1:0] mask_reg, mask_next;
    logic [NUM_IRQ-1:0] in_service_reg, in_service_next;
    logic [NUM_IRQ-1:0] irq_prev_reg;
    state_t             state_reg;
    logic [3:0]         id_reg;
    logic               int_reg;

    logic [11:0]        offset;
    logic               hit;
    logic [1:0]         reg_sel;
    logic               wr_en;
    logic [NUM_IRQ-1:0] wr_bits;
    logic [NUM_IRQ-1:0] w1c_bits;
    logic               eoi_wr;
    logic               ack_fire;
    logic [NUM_IRQ-1:0] ack_bits;
    logic [NUM_IRQ-1:0] edges;

    logic               cand_valid;
    logic [3:0]         cand_idx;
    logic [NUM_IRQ-1:0] cand_onehot;
    logic               isr_valid;
    logic [3:0]         isr_idx;
    logic [NUM_IRQ-1:0] isr_onehot;

    logic               rd_sel;
    logic [15:0]        rd_data;

    // Address decode: modular subtraction keeps the window check a single compare.
    assign offset   = bus.address - BASE_ADDR;
    assign hit      = (offset < 12'd4);
    assign reg_sel  = offset[1:0];
    assign wr_en    = bus.memwt && hit;
    assign wr_bits  = bus.wr_data[NUM_IRQ-1:0];
    assign w1c_bits = (wr_en && reg_sel == REG_PENDING) ? wr_bits : '0;
    assign eoi_wr   = wr_en && (reg_sel == REG_EOI);
    assign ack_fire = (state_reg == REQ) && bus.intack;
    assign edges    = irq & ~irq_prev_reg;

    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_ack
            assign ack_bits[gi] = ack_fire && (id_reg == 4'(gi));
        end
    endgenerate

    irq_prio_enc #(.WIDTH(NUM_IRQ)) u_cand_enc (
        .req    (pending_reg & mask_reg),
        .valid  (cand_valid),
        .idx    (cand_idx),
        .onehot (cand_onehot)
    );

    irq_prio_enc #(.WIDTH(NUM_IRQ)) u_isr_enc (
        .req    (in_service_reg),
        .valid  (isr_valid),
        .idx    (isr_idx),
        .onehot (isr_onehot)
    );

    // New edges are OR-ed in last so they win over W1C and acknowledge clears.
    assign pending_next    = (pending_reg & ~w1c_bits & ~ack_bits) | edges;
    assign mask_next       = (wr_en && reg_sel == REG_MASK) ? wr_bits : mask_reg;
    assign in_service_next = (in_service_reg & ~(eoi_wr ? isr_onehot : '0)) | ack_bits;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_reg    <= '0;
            mask_reg       <= '0;
            in_service_reg <= '0;
            irq_prev_reg   <= '0;
        end else begin
            pending_reg    <= pending_next;
            mask_reg       <= mask_next;
            in_service_reg <= in_service_next;
            irq_prev_reg   <= irq;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            id_reg    <= 4'd0;
            int_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cand_valid && !isr_valid) begin
                        id_reg    <= cand_idx;
                        int_reg   <= 1'b1;
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    if (bus.intack) begin
                        int_reg   <= 1'b0;
                        state_reg <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (!isr_valid) begin
                        state_reg <= IDLE;
                    end
`ifdef IRQ_CTRL_NESTING_EN
                    else if (cand_valid && (cand_idx < isr_idx)) begin
                        id_reg    <= cand_idx;
                        int_reg   <= 1'b1;
                        state_reg <= REQ;
                    end
`endif
                end
                default: begin
                    state_reg <= IDLE;
                    int_reg   <= 1'b0;
                end
            endcase
        end
    end

    // Acknowledge owns the data bus; only a real REQ returns a non-zero ID.
    always_comb begin
        rd_sel  = 1'b0;
        rd_data = 16'h0000;
        if (bus.intack) begin
            rd_sel = 1'b1;
            if (state_reg == REQ) begin
                rd_data = {12'h000, id_reg};
            end
        end else if (hit && !bus.memwt) begin
            rd_sel = 1'b1;
            case (reg_sel)
                REG_PENDING:   rd_data = 16'(pending_reg);
                REG_MASK:      rd_data = 16'(mask_reg);
                REG_INSERVICE: rd_data = 16'(in_service_reg);
                default:       rd_data = 16'h0000;
            endcase
        end
    end

    assign bus.rd_sel  = rd_sel;
    assign bus.rd_data = rd_data;
    assign bus.int_o   = int_reg;

    logic unused_bits;
    assign unused_bits = ^{isr_idx, cand_onehot, bus.wr_data};

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: per-cycle vector table plus reset and nesting sequences.
// The nesting sequence expects preemption only when IRQ_CTRL_NESTING_EN is defined.
module tb_irq_ctrl;

    localparam logic [11:0] A_PEND = 12'hFF0;
    localparam logic [11:0] A_MASK = 12'hFF1;
    localparam logic [11:0] A_ISR  = 12'hFF2;
    localparam logic [11:0] A_EOI  = 12'hFF3;
    localparam logic [11:0] A_NONE = 12'h000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       next_rst = 1'b0;
    logic [7:0] irq = 8'h00;

    int errors = 0;
    int checks = 0;

    irq_ctrl_if bus_if ();

    irq_ctrl #(.NUM_IRQ(8), .BASE_ADDR(12'hFF0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .irq   (irq),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  irq;
        logic [11:0] addr;
        logic [15:0] wdata;
        logic        memwt;
        logic        intack;
        logic        exp_int;
        logic        exp_sel;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [7:0] i, input logic [11:0] a, input logic [15:0] d,
                       input logic w, input logic k, input logic ei, input logic es,
                       input logic [15:0] ed);
        vec_t v;
        v.irq = i; v.addr = a; v.wdata = d; v.memwt = w; v.intack = k;
        v.exp_int = ei; v.exp_sel = es; v.exp_data = ed;
        vecs.push_back(v);
    endtask

    // Inputs change just after a rising edge; outputs are sampled on the falling edge.
    task automatic drive(input logic [7:0] i, input logic [11:0] a, input logic [15:0] d,
                         input logic w, input logic k);
        @(posedge clk);
        #1;
        rst_n          = next_rst;
        irq            = i;
        bus_if.address = a;
        bus_if.wr_data = d;
        bus_if.memwt   = w;
        bus_if.intack  = k;
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input logic exp);
        check({name, ".int_o"}, {15'h0, bus_if.int_o}, {15'h0, exp});
    endtask

    task automatic check_read(input string name, input logic [15:0] exp);
        check({name, ".rd_sel"}, {15'h0, bus_if.rd_sel}, 16'h0001);
        check({name, ".rd_data"}, bus_if.rd_data, exp);
    endtask

    initial begin
        bus_if.address = A_NONE;
        bus_if.wr_data = 16'h0000;
        bus_if.memwt   = 1'b0;
        bus_if.intack  = 1'b0;

        // Reset state
        next_rst = 1'b0;
        drive(8'h00, A_NONE, 16'h0, 1'b0, 1'b0);
        drive(8'h00, A_NONE, 16'h0, 1'b0, 1'b0);
        check_int("reset", 1'b0);
        next_rst = 1'b1;
        drive(8'h00, A_PEND, 16'h0, 1'b0, 1'b0);
        check_read("reset.pending", 16'h0000);
        drive(8'h00, A_MASK, 16'h0, 1'b0, 1'b0);
        check_read("reset.mask", 16'h0000);
        drive(8'h00, A_ISR, 16'h0, 1'b0, 1'b0);
        check_read("reset.inservice", 16'h0000);
        $display("reset checks done");

        // Single source, ack precedence over a coincident MASK read
        add(8'h00, A_MASK, 16'h0004, 1, 0, 0, 0, 16'h0000);
        add(8'h04, A_NONE, 16'h0000, 0, 0, 0, 0, 16'h0000);
        add(8'h00, A_NONE, 16'h0000, 0, 0, 0, 0, 16'h0000);
        add(8'h00, A_PEND, 16'h0000, 0, 0, 1, 1, 16'h0004);
        add(8'h00, A_MASK, 16'h0000, 0, 1, 1, 1, 16'h0002);
        add(8'h00, A_PEND, 16'h0000, 0, 0, 0, 1, 16'h0000);
        add(8'h00, A_ISR,  16'h0000, 0, 0, 0, 1, 16'h0004);
        add(8'h00, A_EOI,  16'h0000, 1, 0, 0, 0, 16'h0000);
        add(8'h00, A_ISR,  16'h0000, 0, 0, 0, 1, 16'h0000);
        add(8'h00, A_EOI,  16'h0000, 0, 0, 0, 1, 16'h0000);
        // Two simultaneous sources; spurious ack while in SERVICE
        add(8'h00, A_MASK, 16'h00FF, 1, 0, 0, 0, 16'h0000);
        add(8'h22, A_NONE, 16'h0000, 0, 0, 0, 0, 16'h0000);
        add(8'h00, A_NONE, 16'h0000, 0, 0, 0, 0, 16'h0000);
        add(8'h00, A_PEND, 16'h0000, 0, 0, 1, 1, 16'h0022);
        add(8'h00, A_NONE, 16'h0000, 0, 1, 1, 1, 16'h0001);
        add(8'h00, A_ISR,  16'h0000, 0, 1, 0, 1, 16'h0000);
        add(8'h00, A_ISR,  16'h0000, 0, 0, 0, 1, 16'h0002);
        add(8'h00, A_EOI,  16'h1234, 1, 0, 0, 0, 16'h0000);
        add(8'h00, A_NONE, 16'h0000, 0, 0, 0, 0, 16'h0000);
        add(8'h00, A_NONE, 16'h0000, 0, 0, 0, 0, 16'h0000);
        add(8'h00, A_PEND, 16'h0000, 0, 0, 1, 1, 16'h0020);
        add(8'h00, A_NONE, 16'h0000, 0, 1, 1, 1, 16'h0005);
        add(8'h00, A_ISR,  16'h0000, 0, 0, 0, 1, 16'h0020);
        add(8'h00, A_EOI,  16'h0000, 1, 0, 0, 0, 16'h0000);
        add(8'h00, A_ISR,  16'h0000, 0, 0, 0, 1, 16'h0000);
        // Masked source pends silently, then unmasking raises INT
        add(8'h00, A_MASK, 16'h0000, 1, 0, 0, 0, 16'h0000);
        add(8'h08, A_NONE, 16'h0000, 0, 0, 0, 0, 16'h0000);
        add(8'h00, A_PEND, 16'h0000, 0, 0, 0, 1, 16'h0008);
        add(8'h00, A_PEND, 16'h0000, 0, 0, 0, 1, 16'h0008);
        add(8'h00, A_MASK, 16'h0008, 1, 0, 0, 0, 16'h0000);
        add(8'h00, A_NONE, 16'h0000, 0, 0, 0, 0, 16'h0000);
        add(8'h00, A_NONE, 16'h0000, 0, 1, 1, 1, 16'h0003);
        add(8'h00, A_ISR,  16'h0000, 0, 0, 0, 1, 16'h0008);
        add(8'h00, A_EOI,  16'h0000, 1, 0, 0, 0, 16'h0000);
        add(8'h00, A_NONE, 16'h0000, 0, 0, 0, 0, 16'h0000);
        // New edge and W1C on the same bit: set wins; plain W1C clears
        add(8'h00, A_MASK, 16'h0000, 1, 0, 0, 0, 16'h0000);
        add(8'h08, A_PEND, 16'h0008, 1, 0, 0, 0, 16'h0000);
        add(8'h00, A_PEND, 16'h0000, 0, 0, 0, 1, 16'h0008);
        add(8'h00, A_PEND, 16'h0008, 1, 0, 0, 0, 16'h0000);
        add(8'h00, A_PEND, 16'h0000, 0, 0, 0, 1, 16'h0000);

        for (int n = 0; n < vecs.size(); n++) begin
            string nm;
            nm = $sformatf("vec%0d", n);
            drive(vecs[n].irq, vecs[n].addr, vecs[n].wdata, vecs[n].memwt, vecs[n].intack);
            check_int(nm, vecs[n].exp_int);
            check({nm, ".rd_sel"}, {15'h0, bus_if.rd_sel}, {15'h0, vecs[n].exp_sel});
            if (vecs[n].exp_sel)
                check({nm, ".rd_data"}, bus_if.rd_data, vecs[n].exp_data);
            $display("vec%0d irq=%02h addr=%03h wt=%0b ack=%0b -> int=%0b sel=%0b data=%04h",
                     n, vecs[n].irq, vecs[n].addr, vecs[n].memwt, vecs[n].intack,
                     bus_if.int_o, bus_if.rd_sel, bus_if.rd_data);
        end

        // Reset while in REQ
        drive(8'h00, A_MASK, 16'h0001, 1'b1, 1'b0);
        drive(8'h01, A_NONE, 16'h0, 1'b0, 1'b0);
        drive(8'h00, A_NONE, 16'h0, 1'b0, 1'b0);
        drive(8'h00, A_NONE, 16'h0, 1'b0, 1'b0);
        check_int("rstreq.before", 1'b1);
        next_rst = 1'b0;
        drive(8'h00, A_NONE, 16'h0, 1'b0, 1'b0);
        check_int("rstreq.assert", 1'b1);
        next_rst = 1'b1;
        drive(8'h00, A_PEND, 16'h0, 1'b0, 1'b0);
        check_int("rstreq.after", 1'b0);
        check_read("rstreq.pending", 16'h0000);
        drive(8'h00, A_MASK, 16'h0, 1'b0, 1'b0);
        check_read("rstreq.mask", 16'h0000);
        drive(8'h00, A_ISR, 16'h0, 1'b0, 1'b0);
        check_read("rstreq.inservice", 16'h0000);
        drive(8'h00, A_NONE, 16'h0, 1'b0, 1'b1);
        check_read("idle_ack", 16'h0000);
        drive(8'h00, A_ISR, 16'h0, 1'b0, 1'b0);
        check_int("idle_ack.after", 1'b0);
        check_read("idle_ack.inservice", 16'h0000);
        $display("reset-in-REQ sequence done");

        // Preemption of an in-service source
        drive(8'h00, A_MASK, 16'h00FF, 1'b1, 1'b0);
        drive(8'h10, A_NONE, 16'h0, 1'b0, 1'b0);
        drive(8'h00, A_NONE, 16'h0, 1'b0, 1'b0);
        drive(8'h00, A_NONE, 16'h0, 1'b0, 1'b1);
        check_int("nest.req4", 1'b1);
        check_read("nest.ack4", 16'h0004);
        drive(8'h01, A_NONE, 16'h0, 1'b0, 1'b0);
        check_int("nest.pulse0", 1'b0);
        drive(8'h00, A_NONE, 16'h0, 1'b0, 1'b0);
        check_int("nest.wait", 1'b0);
`ifdef IRQ_CTRL_NESTING_EN
        drive(8'h00, A_NONE, 16'h0, 1'b0, 1'b1);
        check_int("nest.req0", 1'b1);
        check_read("nest.ack0", 16'h0000);
        drive(8'h00, A_ISR, 16'h0, 1'b0, 1'b0);
        check_int("nest.svc", 1'b0);
        check_read("nest.isr11", 16'h0011);
        drive(8'h00, A_EOI, 16'h0, 1'b1, 1'b0);
        drive(8'h00, A_ISR, 16'h0, 1'b0, 1'b0);
        check_read("nest.isr10", 16'h0010);
        drive(8'h00, A_EOI, 16'h0, 1'b1, 1'b0);
        drive(8'h00, A_ISR, 16'h0, 1'b0, 1'b0);
        check_int("nest.done", 1'b0);
        check_read("nest.isr00", 16'h0000);
`else
        drive(8'h00, A_ISR, 16'h0, 1'b0, 1'b0);
        check_int("nonest.held", 1'b0);
        check_read("nonest.isr10", 16'h0010);
        drive(8'h00, A_PEND, 16'h0, 1'b0, 1'b0);
        check_int("nonest.held2", 1'b0);
        check_read("nonest.pend01", 16'h0001);
        drive(8'h00, A_EOI, 16'h0, 1'b1, 1'b0);
        check_int("nonest.eoi", 1'b0);
        drive(8'h00, A_NONE, 16'h0, 1'b0, 1'b0);
        check_int("nonest.idle", 1'b0);
        drive(8'h00, A_NONE, 16'h0, 1'b0, 1'b0);
        check_int("nonest.req_pending", 1'b0);
        drive(8'h00, A_NONE, 16'h0, 1'b0, 1'b1);
        check_int("nonest.req0", 1'b1);
        check_read("nonest.ack0", 16'h0000);
        drive(8'h00, A_ISR, 16'h0, 1'b0, 1'b0);
        check_int("nonest.svc", 1'b0);
        check_read("nonest.isr01", 16'h0001);
        drive(8'h00, A_EOI, 16'h0, 1'b1, 1'b0);
        drive(8'h00, A_ISR, 16'h0, 1'b0, 1'b0);
        check_read("nonest.isr00", 16'h0000);
`endif
        $display("nesting sequence done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Programmable interrupt controller directly upstream of the CPU core.
- Collects up to NUM_IRQ peripheral request lines and drives the core's single INT input.
- Answers the core's interrupt-acknowledge cycle by placing the winning source ID on the read-data bus. The core adds 0x07F0 to that ID to index its vector table.
- Registers are memory-mapped on the core's 12-bit address / 16-bit data bus.

Parameters:
- NUM_IRQ, 8, number of request lines (1..16); index 0 is highest priority.
- BASE_ADDR, 12'hFF0, word address of register 0; occupies BASE_ADDR..BASE_ADDR+3.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- irq  input  NUM_IRQ  peripheral requests, synchronous to clk, rising-edge triggered.
- address  input  12  core address bus.
- wr_data  input  16  core write data (core data_out).
- memwt  input  1  core write strobe.
- intack  input  1  core acknowledge; high for exactly one cycle.
- int_o  output  1  to core INT.
- rd_data  output  16  read data / vector ID, valid when rd_sel=1.
- rd_sel  output  1  bus-mux select: this block drives the core's data_in this cycle.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - pending=0, mask=0, in_service=0, irq_prev=0, state=IDLE.
  - int_o=0, rd_sel=0, rd_data=0.
  - Reset mid-request drops int_o on the next edge.
- Edge detect: pending[i] sets on the cycle after irq[i]=1 with irq_prev[i]=0. Pending sets regardless of mask.
- Register map (word offsets from BASE_ADDR):
  - 0 PENDING: RO; write is W1C.
  - 1 MASK: RW; 1 = enabled.
  - 2 INSERVICE: RO.
  - 3 EOI: write of any data clears the highest-priority set in_service bit. Reads return 0.
  - Unused upper bits read 0.
- Reads are combinational:
  - rd_sel=1 and rd_data=register whenever address hits the map and memwt=0.
  - Writes take effect at the clock edge with memwt=1.
- Simultaneous events: a new edge and a W1C on the same bit in the same cycle leaves pending set (set wins).
- Candidate = lowest index i with pending[i] & mask[i]. The priority encoder is combinational.
- FSM states IDLE, REQ, SERVICE:
  - IDLE: if a candidate exists and in_service==0, latch id=candidate and go to REQ. int_o=1 from the following cycle.
  - REQ: int_o=1. The id stays latched even if a higher-priority source arrives or the mask changes.
  - REQ with intack=1, in that same cycle (combinational): rd_sel=1, rd_data={12'b0, id[3:0]}.
  - REQ with intack=1, at the edge: clear pending[id], set in_service[id], int_o=0, go to SERVICE.
  - SERVICE: int_o=0. When in_service becomes 0 (via EOI), go to IDLE.
- Other acknowledge cases:
  - intack in IDLE or SERVICE: rd_sel=1, rd_data=0, no state change (spurious acknowledge).
  - intack takes precedence over a coincident register read for rd_data.
- Latency: irq edge to int_o=1 is 2 cycles minimum (pending set, then REQ).
- EOI while in_service==0 is ignored.

Optional Feature:
- Macro: IRQ_CTRL_NESTING_EN.
- Defined:
  - In SERVICE, a candidate with priority strictly higher than the highest set in_service bit latches a new id and enters REQ. in_service may then hold several bits.
  - EOI clears only the highest-priority bit.
  - Return to IDLE when in_service==0; otherwise back to SERVICE after each acknowledge.
- Undefined: at most one in_service bit; no request is raised while in_service!=0.

Decomposition:
- Package irq_ctrl_pkg: state enum (IDLE, REQ, SERVICE), register offset constants (REG_PENDING=0, REG_MASK=1, REG_INSERVICE=2, REG_EOI=3), vector base constant 16'h07F0 (documentation and bench use).
- Sub-module irq_prio_enc: parameterised lowest-index-wins priority encoder with valid flag. It is used twice: candidate selection and highest in_service selection.

Test Plan:
- Write MASK=0x0004, pulse irq[2] one cycle -> int_o=1 two cycles later. On intack, rd_sel=1 and rd_data=0x0002. Next cycle pending=0, INSERVICE=0x0004, int_o=0.
- MASK=0x00FF, pulse irq[5] and irq[1] in the same cycle -> acknowledged ID is 1. After EOI write, int_o reasserts and the next acknowledge returns ID 5.
- MASK=0, pulse irq[3] -> PENDING reads 0x0008 and int_o stays 0. Write MASK=0x0008 -> int_o=1.
- Write PENDING=0x0008 on the same cycle irq[3] rises -> PENDING still 0x0008.
- Assert rst_n=0 while in REQ -> int_o=0 and all registers read 0 after the edge. Pulse intack in IDLE -> rd_data=0, state unchanged.
- With IRQ_CTRL_NESTING_EN: service irq[4], then pulse irq[0] -> int_o=1 and acknowledge returns 0, INSERVICE=0x0011. Two EOIs -> 0x0010, then 0x0000. Without the macro, int_o stays 0 until the first EOI.
